// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and responder FSM state type.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_BURST
  } wb_state_e;

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone B3 bus between a master (dtlb walker / dcache) and the memory responder.
interface wb_mem_responder_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Next word address of a Wishbone burst: const holds, incr steps linearly
// or wraps inside an aligned 4/8/16-word block.
module wb_burst_addr_gen
  import wb_pkg::*;
(
  input  logic [29:0] adr,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [29:0] adr_nxt
);

  // Only the wrapped low bits move for wrap bursts; upper bits are held.
  always_comb begin
    adr_nxt = adr;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: adr_nxt      = adr + 30'd1;
        BTE_WRAP4:  adr_nxt[1:0] = adr[1:0] + 2'd1;
        BTE_WRAP8:  adr_nxt[2:0] = adr[2:0] + 3'd1;
        default:    adr_nxt[3:0] = adr[3:0] + 4'd1;
      endcase
    end
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 memory responder: classic and registered-feedback bursts over an
// on-chip word store, with wait states on the first beat and ack/err/rty replies.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  wb_mem_responder_if.slave bus
);

  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WS_M1     = 4'(WAIT_STATES - 1);

  // Window test done in 33 bits so a full 4 GiB window cannot overflow.
  function automatic logic in_window(input logic [29:0] w);
    logic [31:0] off;
    off = {w, 2'b00} - BASE_ADDR;
    return {1'b0, off} < WIN_BYTES;
  endfunction

  wb_state_e   state, state_n;
  logic [29:0] adr_q, adr_nxt;
  logic        we_q, hold_q;
  logic [3:0]  sel_q, mem_sel;
  logic [31:0] dat_q, mem_dat;
  logic [2:0]  cti_q, cti_gen;
  logic [1:0]  bte_q;
  logic [3:0]  cnt_q;
  logic        accept, adv, mem_we, ack, err, rty, win_b;
  logic        unused_adr_lsb;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] widx;

  assign unused_adr_lsb = ^bus.wb_adr_i[1:0];
  assign widx           = adr_q[DEPTH_LOG2-1:0];
  assign win_b          = in_window(adr_q);

  wb_burst_addr_gen u_agen (
    .adr     (adr_q),
    .cti     (cti_gen),
    .bte     (bte_q),
    .adr_nxt (adr_nxt)
  );

  // Next state, beat terminations and store write strobes.
  always_comb begin
    state_n = state;
    ack     = 1'b0;
    err     = 1'b0;
    rty     = 1'b0;
    accept  = 1'b0;
    adv     = 1'b0;
    mem_we  = 1'b0;
    mem_sel = sel_q;
    mem_dat = dat_q;
    cti_gen = cti_q;
    case (state)
      ST_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          accept  = 1'b1;
          state_n = (hold_i || WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.wb_cyc_i)      state_n = ST_IDLE;
        else if (cnt_q == 4'd0) state_n = ST_RESP;
      end
      ST_RESP: begin
        if (!bus.wb_cyc_i) begin
          state_n = ST_IDLE;
        end else begin
          rty    = hold_q;
          ack    = !hold_q && win_b;
          err    = !hold_q && !win_b;
          mem_we = ack && we_q;
          if (hold_q || !win_b || !(cti_q == CTI_CONST || cti_q == CTI_INCR)) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_BURST;
            adv     = 1'b1;
          end
        end
      end
      ST_BURST: begin
        // Registered-feedback beats: master qualifiers are taken live each beat.
        cti_gen = bus.wb_cti_i;
        mem_sel = bus.wb_sel_i;
        mem_dat = bus.wb_dat_i;
        if (!bus.wb_cyc_i) begin
          state_n = ST_IDLE;
        end else if (bus.wb_stb_i) begin
          ack    = win_b;
          err    = !win_b;
          mem_we = ack && bus.wb_we_i;
          if (!win_b || !(bus.wb_cti_i == CTI_CONST || bus.wb_cti_i == CTI_INCR))
            state_n = ST_IDLE;
          else
            adv = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, latched request fields, beat address and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      adr_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      cti_q  <= CTI_CLASSIC;
      bte_q  <= BTE_LINEAR;
      hold_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        adr_q  <= bus.wb_adr_i[31:2];
        we_q   <= bus.wb_we_i;
        sel_q  <= bus.wb_sel_i;
        dat_q  <= bus.wb_dat_i;
        cti_q  <= bus.wb_cti_i;
        bte_q  <= bus.wb_bte_i;
        hold_q <= hold_i;
        cnt_q  <= WS_M1;
      end else begin
        if (adv) adr_q <= adr_nxt;
        if (state == ST_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Byte-lane store write at the ack edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_sel[i]) mem[widx][8*i +: 8] <= mem_dat[8*i +: 8];
    end
  end

  // Asynchronous read gives write-first behaviour on the following beat.
  assign bus.wb_dat_o = ack ? mem[widx] : 32'h0;
  assign bus.wb_ack_o = ack;
  assign bus.wb_err_o = err;
  assign bus.wb_rty_o = rty;

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Wishbone B3 slave (responder) serving 32-bit classic and registered-feedback burst cycles from an on-chip word-addressed store.
- Sits opposite the dtlb page-table-walk master and the dcache refill/writeback master, which drive cyc/stb/we/adr/sel/cti/bte.
- Used as a page-table / backing-memory target in subsystem simulation and FPGA bring-up.
- Produces ack, err or rty per beat, with programmable wait states.

Parameters:
- DEPTH_LOG2, 12: store holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte base address of the window; must be aligned to 4*2^DEPTH_LOG2.
- WAIT_STATES, 1: extra cycles before the first ack of every cycle; legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address; bits [1:0] ignored.
- wb_sel_i  in  4  byte lane enables.
- wb_dat_i  in  32  write data.
- wb_cti_i  in  3  000 classic, 001 const burst, 010 incr burst, 111 end of burst.
- wb_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- hold_i  in  1  responder busy; new cycles are answered with rty.
- wb_dat_o  out  32  read data, valid while ack is high.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  out-of-window termination.
- wb_rty_o  out  1  retry termination.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - ack/err/rty/dat_o = 0, wait counter = 0.
  - Store contents are not cleared.
  - An ack pending when reset asserts is lost.
- States: IDLE, WAIT, RESP, BURST.
- Acceptance (IDLE): request accepted at the edge where cyc&stb = 1.
  - Latch adr[31:2], we, sel, dat_i, cti, bte.
  - Latch in_window = (adr - BASE_ADDR) < 4*2^DEPTH_LOG2.
- Retry: if hold_i = 1 at acceptance, assert rty for exactly one cycle, then return to IDLE. No store access.
- Wait states: WAIT counts WAIT_STATES cycles. With WAIT_STATES = 0, go directly to RESP.
  - First-beat latency = 1 + WAIT_STATES cycles after acceptance.
- Exactly one termination signal is high per beat.
- RESP (first beat), single cycle:
  - In window: ack = 1. Reads present store[word]. Writes update only byte lanes with sel = 1, at the ack edge.
  - Out of window: err = 1, no write, dat_o = 0.
- After RESP or BURST:
  - Classic (cti 000), cti 111, or err: go to IDLE; ack/err drop the next cycle. Back-to-back classic transfers therefore cost 2 + WAIT_STATES cycles each.
  - cti 001/010 with stb still high: go to BURST.
- BURST: ack every cycle with zero wait, while cyc&stb.
  - Address for next beat is precomputed: cti 010 increments; cti 001 holds the address.
  - bte 00: word address +1, full width.
  - bte 01/10/11: low 2/3/4 word-address bits increment modulo 4/8/16; upper bits held.
  - The beat with cti = 111 is the last; go to IDLE after it.
  - Master sampled cti/sel/dat_i/we each beat.
- Burst crossing the window end: that beat gets err instead of ack, and the burst terminates (IDLE).
- stb low with cyc high during BURST: insert a wait. No ack; address is not advanced. Resume when stb returns.
- cyc low in any non-IDLE state: abort to IDLE the next edge. Outputs drop; no write for the aborted beat.
- Read-during-write of the same word within a burst: returns newly written data on the following beat (write-first).

Decomposition:
- Package wb_pkg: CTI_CLASSIC/CTI_CONST/CTI_INCR/CTI_EOB, BTE_LINEAR/WRAP4/WRAP8/WRAP16 constants, FSM state enum.
- One sub-module, wb_burst_addr_gen: combinational next-word-address from current address, cti, bte. Reusable by the master side.

Test Plan:
- WAIT_STATES = 1: classic write 0xDEADBEEF to 0x10 with sel = 4'b1111, then classic read of 0x10 -> read ack exactly 2 cycles after acceptance, dat_o = 0xDEADBEEF.
- Byte enables: write 0x11223344 with sel = 4'b0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
- Incrementing wrap4 read burst of 4 beats starting at 0x0C -> words 0x0C, 0x00, 0x04, 0x08 acked on consecutive cycles after the first; IDLE after the cti = 111 beat.
- Read of BASE_ADDR + 0x4000 with DEPTH_LOG2 = 12 -> err for one cycle, ack = 0; store unchanged, checked by readback.
- hold_i = 1 at acceptance -> rty pulse one cycle, no write. Retry with hold_i = 0 -> normal ack.
- Async rst asserted mid-linear-burst (beat 2 of 8) -> ack = 0 immediately. After release, a new classic read completes normally with previously written data intact.
